mux_2x1_64_arbiter: RTL and testbench

Round-robin arbiter that shares one 2:1 WIDTH-bit mux datapath between two requesters, A and B, each using a valid/ready handshake. The block drives the mux select, registers the selected word, and presents it on a single valid/ready output port. It sits between two producers (e.g. the ALU result and the load unit) and a single-consumer write path.

---
 rtl/mux_2x1_64_arbiter.sv | 129 ++++++++++++
 tb/tb_mux_2x1_64_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_2x1_64_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between requesters A and B, with a registered output.
// Optional grant counters are enabled by defining MUX_ARB_STATS_EN.
module mux_2x1_64_arbiter #(
  parameter int unsigned WIDTH       = 64,
  parameter bit          FIRST_GRANT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
`ifdef MUX_ARB_STATS_EN
  output logic [15:0]      a_grant_cnt,
  output logic [15:0]      b_grant_cnt,
`endif
  input  logic             out_ready
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             src_q, src_d;
  logic             last_grant_q, last_grant_d;
  logic             load_en;
  logic             grant_a, grant_b;

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign load_en   = !out_valid || out_ready;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (load_en) begin
      if (a_valid && b_valid) begin
        // Contention: favour whichever requester did not win last.
        grant_a = last_grant_q;
        grant_b = !last_grant_q;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Without a grant the select parks on the last winner so the mux does not toggle.
  always_comb begin
    if (grant_a) begin
      sel = 1'b0;
    end else if (grant_b) begin
      sel = 1'b1;
    end else begin
      sel = last_grant_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StEmpty: begin
        if (grant_a || grant_b) begin
          state_d = StFull;
        end
      end
      StFull: begin
        if (!(grant_a || grant_b) && out_ready) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (grant_a || grant_b) begin
      data_d       = sel ? b_data : a_data;
      src_d        = sel;
      last_grant_d = sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StEmpty;
      data_q       <= '0;
      src_q        <= 1'b0;
      last_grant_q <= ~FIRST_GRANT;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef MUX_ARB_STATS_EN
  logic [15:0] a_cnt_q, b_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      if (grant_a && (a_cnt_q != 16'hFFFF)) begin
        a_cnt_q <= a_cnt_q + 16'd1;
      end
      if (grant_b && (b_cnt_q != 16'hFFFF)) begin
        b_cnt_q <= b_cnt_q + 16'd1;
      end
    end
  end

  assign a_grant_cnt = a_cnt_q;
  assign b_grant_cnt = b_cnt_q;
`endif

endmodule

// File: tb/tb_mux_2x1_64_arbiter.sv
// Self-checking bench for mux_2x1_64_arbiter: directed vector table, reset corner case,
// randomized traffic against a transaction-level model, and grant counters when enabled.
module tb_mux_2x1_64_arbiter;
  localparam int unsigned W = 64;
  localparam logic [W-1:0] ONE  = 64'h1;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk = 1'b0;
  logic         reset;
  logic         a_valid, b_valid, a_ready, b_ready, sel;
  logic [W-1:0] a_data, b_data, out_data;
  logic         out_valid, out_src, out_ready;
`ifdef MUX_ARB_STATS_EN
  logic [15:0]  a_grant_cnt, b_grant_cnt;
`endif

  mux_2x1_64_arbiter #(.WIDTH(W), .FIRST_GRANT(1'b0)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
`ifdef MUX_ARB_STATS_EN
    .a_grant_cnt (a_grant_cnt),
    .b_grant_cnt (b_grant_cnt),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Transaction-level model: who is holding the output word, and who won last.
  logic         m_full, m_src, m_last;
  logic [W-1:0] m_word;
  int           m_acnt, m_bcnt;

  // Values sampled from the DUT by run_cycle.
  logic         s_ar, s_br, s_sel, s_ov, s_src;
  logic [W-1:0] s_od;

  typedef struct {
    logic         av;
    logic         bv;
    logic [W-1:0] ad;
    logic [W-1:0] bd;
    logic         ordy;
    logic         ar;
    logic         br;
    logic         sl;
    logic         ov;
    logic [W-1:0] od;
    logic         src;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_word = '0;
    m_src  = 1'b0;
    m_last = 1'b1;  // rotation starts so A (FIRST_GRANT=0) wins first contention
    m_acnt = 0;
    m_bcnt = 0;
  endtask

  // Winner for this cycle: -1 none, 0 A, 1 B.
  function automatic int model_winner();
    int n;
    n = int'(a_valid) + int'(b_valid);
    if (m_full && !out_ready) return -1;
    if (n == 0) return -1;
    if (n == 2) return m_last ? 0 : 1;
    return a_valid ? 0 : 1;
  endfunction

  // Apply current inputs for one clock; optionally compare every output against the model.
  task automatic run_cycle(input bit use_model);
    int w;
    #1;
    w = model_winner();
    s_ar = a_ready; s_br = b_ready; s_sel = sel;
    if (use_model) begin
      chk("a_ready", {63'd0, s_ar}, {63'd0, w == 0});
      chk("b_ready", {63'd0, s_br}, {63'd0, w == 1});
      chk("sel", {63'd0, s_sel}, {63'd0, (w < 0) ? m_last : (w == 1)});
    end
    @(posedge clk);
    if (w >= 0) begin
      m_full = 1'b1;
      m_word = (w == 1) ? b_data : a_data;
      m_src  = (w == 1);
      m_last = (w == 1);
      if (w == 0) m_acnt = (m_acnt < 65535) ? m_acnt + 1 : 65535;
      else        m_bcnt = (m_bcnt < 65535) ? m_bcnt + 1 : 65535;
    end else if (out_ready) begin
      m_full = 1'b0;
    end
    #1;
    s_ov = out_valid; s_od = out_data; s_src = out_src;
    if (use_model) begin
      chk("out_valid", {63'd0, s_ov}, {63'd0, m_full});
      chk("out_data", s_od, m_word);
      chk("out_src", {63'd0, s_src}, {63'd0, m_src});
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // av bv ad bd ordy | ar br sel | ov od src
    vq.push_back('{1'b0, 1'b0, '0,  '0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0,   1'b0});
    vq.push_back('{1'b1, 1'b1, ONE, ONES, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ONE,  1'b0});
    vq.push_back('{1'b1, 1'b1, ONE, ONES, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, ONES, 1'b1});
    vq.push_back('{1'b1, 1'b1, ONE, ONES, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ONE,  1'b0});
    vq.push_back('{1'b1, 1'b1, ONE, ONES, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, ONES, 1'b1});
    vq.push_back('{1'b1, 1'b0, ONE, '0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ONE,  1'b0});
    vq.push_back('{1'b0, 1'b1, '0,  ONES, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ONE,  1'b0});
    vq.push_back('{1'b0, 1'b1, '0,  ONES, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ONE,  1'b0});
    vq.push_back('{1'b0, 1'b1, '0,  ONES, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ONE,  1'b0});
    vq.push_back('{1'b0, 1'b1, '0,  ONES, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, ONES, 1'b1});
    vq.push_back('{1'b0, 1'b0, '0,  '0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ONES, 1'b1});
    vq.push_back('{1'b0, 1'b0, '0,  '0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ONES, 1'b1});

    foreach (vq[i]) begin
      a_valid = vq[i].av; b_valid = vq[i].bv;
      a_data  = vq[i].ad; b_data  = vq[i].bd;
      out_ready = vq[i].ordy;
      run_cycle(1'b0);
      chk($sformatf("v%0d a_ready", i), {63'd0, s_ar}, {63'd0, vq[i].ar});
      chk($sformatf("v%0d b_ready", i), {63'd0, s_br}, {63'd0, vq[i].br});
      chk($sformatf("v%0d sel", i), {63'd0, s_sel}, {63'd0, vq[i].sl});
      chk($sformatf("v%0d out_valid", i), {63'd0, s_ov}, {63'd0, vq[i].ov});
      chk($sformatf("v%0d out_data", i), s_od, vq[i].od);
      chk($sformatf("v%0d out_src", i), {63'd0, s_src}, {63'd0, vq[i].src});
    end

    // Reset asserted between edges while FULL; outputs must clear without a clock.
    a_valid = 1'b0; b_valid = 1'b1; b_data = 64'hDEAD_BEEF_0123_4567; out_ready = 1'b0;
    run_cycle(1'b1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst out_data", out_data, '0);
    chk("rst out_src", {63'd0, out_src}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    a_valid = 1'b1; a_data = 64'h0BAD_F00D_0000_0001; b_valid = 1'b1; out_ready = 1'b1;
    run_cycle(1'b1);
    chk("rst first grant a_ready", {63'd0, s_ar}, 64'd1);
    chk("rst first grant sel", {63'd0, s_sel}, 64'd0);

    // Randomized traffic; requesters hold valid/data until accepted.
    for (int i = 0; i < 400; i++) begin
      if (!a_valid || s_ar) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_data  = {$urandom, $urandom};
      end
      if (!b_valid || s_br) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_data  = {$urandom, $urandom};
      end
      out_ready = ($urandom_range(0, 3) != 0);
      run_cycle(1'b1);
    end

`ifdef MUX_ARB_STATS_EN
    chk("a_grant_cnt rand", {48'd0, a_grant_cnt}, 64'(m_acnt));
    chk("b_grant_cnt rand", {48'd0, b_grant_cnt}, 64'(m_bcnt));
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_valid = (i < 5); b_valid = (i >= 5);
      a_data = 64'(i); b_data = 64'(i);
      run_cycle(1'b1);
    end
    chk("a_grant_cnt 5", {48'd0, a_grant_cnt}, 64'd5);
    chk("b_grant_cnt 3", {48'd0, b_grant_cnt}, 64'd3);
    a_valid = 1'b1; b_valid = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      run_cycle(1'b0);
    end
    chk("a_grant_cnt sat", {48'd0, a_grant_cnt}, 64'hFFFF);
    chk("b_grant_cnt hold", {48'd0, b_grant_cnt}, 64'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
